// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared types and constants for the truth-table sweeper
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] TT_GOLDEN = 8'h8A;
    localparam int         IDX_W     = 3;
    localparam int         CNT_W     = 4;

endpackage

// File: rtl/tt_capture_slice.sv
// rtl/tt_capture_slice.sv - per-implementation truth-table register and sticky mismatch flag
module tt_capture_slice
    import tt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             exp_i,
    input  logic             y_i,
    output logic [7:0]       tt_o,
    output logic             err_o,
    output logic             mis_o
);

    logic [7:0] tt_q, tt_d;
    logic       err_q, err_d;

    assign mis_o = y_i ^ exp_i;

    always_comb begin
        tt_d  = tt_q;
        err_d = err_q;
        if (clr_i) begin
            tt_d  = 8'h00;
            err_d = 1'b0;
        end else if (we_i) begin
            tt_d[idx_i] = y_i;
            err_d       = err_q | mis_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_q  <= 8'h00;
            err_q <= 1'b0;
        end else begin
            tt_q  <= tt_d;
            err_q <= err_d;
        end
    end

    assign tt_o  = tt_q;
    assign err_o = err_q;

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps {A,B,C} through 8 vectors and checks three Y implementations
module truth_table_sweeper
    import tt_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECTED      = TT_GOLDEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       y_sop,
    input  logic       y_pos,
    input  logic       y_kmap,
    output logic [2:0] abc_out,
    output logic       busy,
    output logic       done,
    output logic       result_valid,
    output logic       pass,
    output logic [2:0] err_mask,
    output logic [3:0] fail_count,
    output logic [2:0] first_fail_idx,
    output logic [7:0] tt_sop,
    output logic [7:0] tt_pos,
    output logic [7:0] tt_kmap
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       abc_q, abc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rv_q, rv_d;
    logic             pass_q, pass_d;
    logic [3:0]       fc_q, fc_d;
    logic [2:0]       ffi_q, ffi_d;

    logic       accept, sample, last, clr, we, any_mis;
    logic [2:0] err_flags, mis;
    logic [7:0] tt_s, tt_p, tt_k;

    assign accept  = (state_q == IDLE) && start && !abort;
    assign sample  = (state_q == HOLD) && (cnt_q == CNT_W'(SETTLE_CYCLES));
    assign last    = (idx_q == 3'd7);
    assign clr     = accept;
    assign we      = sample && !abort;
    assign any_mis = we && (|mis);

    tt_capture_slice u_sop (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .we_i(we), .idx_i(idx_q),
        .exp_i(EXPECTED[idx_q]), .y_i(y_sop), .tt_o(tt_s), .err_o(err_flags[0]), .mis_o(mis[0])
    );
    tt_capture_slice u_pos (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .we_i(we), .idx_i(idx_q),
        .exp_i(EXPECTED[idx_q]), .y_i(y_pos), .tt_o(tt_p), .err_o(err_flags[1]), .mis_o(mis[1])
    );
    tt_capture_slice u_kmap (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .we_i(we), .idx_i(idx_q),
        .exp_i(EXPECTED[idx_q]), .y_i(y_kmap), .tt_o(tt_k), .err_o(err_flags[2]), .mis_o(mis[2])
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            abc_q   <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rv_q    <= 1'b0;
            pass_q  <= 1'b0;
            fc_q    <= 4'd0;
            ffi_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rv_q    <= rv_d;
            pass_q  <= pass_d;
            fc_q    <= fc_d;
            ffi_q   <= ffi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = HOLD;
            HOLD:    if (abort) state_d = IDLE;
                     else if (sample && last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        abc_d  = abc_q;
        busy_d = busy_q;
        done_d = 1'b0;
        rv_d   = rv_q;
        pass_d = pass_q;
        fc_d   = fc_q;
        ffi_d  = ffi_q;
        if (accept) begin
            idx_d  = '0;
            cnt_d  = '0;
            abc_d  = 3'b000;
            busy_d = 1'b1;
            rv_d   = 1'b0;
            pass_d = 1'b0;
            fc_d   = 4'd0;
            ffi_d  = 3'd0;
        end else if (state_q == HOLD) begin
            if (abort) begin
                idx_d  = '0;
                cnt_d  = '0;
                abc_d  = 3'b000;
                busy_d = 1'b0;
                rv_d   = 1'b0;
                pass_d = 1'b0;
            end else if (sample) begin
                cnt_d = '0;
                if (any_mis) begin
                    fc_d = fc_q + 4'd1;
                    // fail_count still zero means this is the first failing vector
                    if (fc_q == 4'd0) ffi_d = idx_q;
                end
                if (!last) begin
                    idx_d = idx_q + 3'd1;
                    abc_d = abc_q + 3'd1;
                end else begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    rv_d   = 1'b1;
                    pass_d = ~(|err_flags) & ~any_mis;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        abc_out        = abc_q;
        busy           = busy_q;
        done           = done_q;
        result_valid   = rv_q;
        pass           = pass_q & rv_q;
        err_mask       = rv_q ? err_flags : 3'b000;
        fail_count     = fc_q;
        first_fail_idx = ffi_q;
        tt_sop         = tt_s;
        tt_pos         = tt_p;
        tt_kmap        = tt_k;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-checking stimulus/checker stage wrapped around the 3-input logic implementations (SOP, POS, Karnaugh forms of Y = ~A&C | B&C).
- Upstream role: drives the shared A,B,C inputs through all 8 combinations.
- Downstream role: captures each implementation's Y, builds its observed truth table and compares it against a golden table.
- Used on the lab board to prove that all three forms are equivalent.

Parameters:
- SETTLE_CYCLES, 2, extra cycles each vector is held before sampling; legal range 0..15.
- EXPECTED, 8'h8A, golden truth table; bit i = Y for {A,B,C} = i.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sweep; level-sampled, honoured only in IDLE.
- abort  in  1  synchronous abort of a sweep in progress.
- y_sop  in  1  Y from the SOP implementation.
- y_pos  in  1  Y from the POS implementation.
- y_kmap  in  1  Y from the Karnaugh implementation.
- abc_out  out  3  registered stimulus {A,B,C}; bit2 = A.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse when a sweep completes.
- result_valid  out  1  results below belong to a completed sweep.
- pass  out  1  all three tables equal EXPECTED.
- err_mask  out  3  per-implementation mismatch flag; bit0 sop, bit1 pos, bit2 kmap.
- fail_count  out  4  vectors (0..8) where any implementation mismatched.
- first_fail_idx  out  3  lowest failing vector index; 0 if none.
- tt_sop, tt_pos, tt_kmap  out  8 each  observed truth tables.

Behaviour:
- Reset (async, rst_n low): every output is 0, state IDLE, vector index 0, hold counter 0.
- States:
  - IDLE: wait for a sweep request.
  - HOLD: drive the current vector and count hold cycles.
  - DONE: one cycle, then return to IDLE.
- IDLE:
  - start=1 and abort=0 at an edge → HOLD.
  - That same edge sets abc_out=000, busy=1 and result_valid=0, and clears tt_*, err_mask, fail_count and first_fail_idx.
  - start and abort together in IDLE → remain IDLE.
- HOLD, vector timing:
  - Each vector is held for SETTLE_CYCLES+1 cycles.
  - Inputs are combinational from abc_out in the same clock domain, so no synchronizer.
- HOLD, sample edge (hold counter == SETTLE_CYCLES):
  - Write y_sop, y_pos and y_kmap into bit [idx] of their tt_* registers.
  - Compare each against EXPECTED[idx]; OR any mismatch into err_mask.
  - If any implementation mismatched, increment fail_count. The first mismatch loads first_fail_idx.
  - If idx < 7: idx++, abc_out++, counter reset to 0.
  - If idx == 7: → DONE. abc_out stays 111.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - result_valid=1.
  - pass = (err_mask == 0).
  - Next edge → IDLE.
- Results hold until the next accepted start or reset.
- Sweep latency: start edge to the done pulse = 8*(SETTLE_CYCLES+1) cycles, plus one cycle in DONE.
- abort in HOLD:
  - → IDLE next edge; busy=0, abc_out=000, result_valid=0, pass=0.
  - No done pulse.
  - Partial tt_* contents remain visible but are not valid.
  - abort in IDLE or DONE is ignored.
- start while busy is ignored; no queueing.
- fail_count saturates naturally at 8; it is 4 bits wide.
- pass and err_mask are meaningful only while result_valid=1; otherwise they read 0.
- Reset mid-sweep aborts immediately to the reset values; no done pulse.

Decomposition:
- Shared package tt_pkg holds:
  - the state enum (IDLE, HOLD, DONE);
  - the default golden constant TT_GOLDEN = 8'h8A;
  - the index width constant (3) and the counter width (4).
- One natural sub-module, tt_capture_slice, instantiated 3×. Per implementation it holds:
  - the 8-bit table register;
  - the sticky mismatch flag;
  - the write-enable/clear inputs, with index and expected bit supplied by the parent.

Test Plan:
- Golden sweep: all three Y inputs modelled correctly, SETTLE_CYCLES=2.
  - done pulses 25 cycles after start; abc_out steps 0..7, 3 cycles each.
  - tt_* = 8'h8A, pass=1, err_mask=000, fail_count=0.
- Faulty SOP: y_sop modelled with minterms 3 and 7 only.
  - tt_sop = 8'h88, err_mask=001, fail_count=1, first_fail_idx=1, pass=0.
- Multiple faults: y_pos tied 0 and y_kmap tied 1.
  - err_mask=110, fail_count=8, first_fail_idx=0, tt_pos=8'h00, tt_kmap=8'hFF.
- Abort: abort asserted at vector 4.
  - IDLE next cycle, busy=0, no done, result_valid=0, abc_out=000.
  - A fresh start completes normally with pass=1.
- Reset and start handling:
  - rst_n pulsed low mid-sweep → all outputs 0 asynchronously.
  - start held high during a sweep → no restart; exactly one done.
- SETTLE_CYCLES=0: each vector lasts 1 cycle; done 9 cycles after start; results identical to the golden sweep.
